addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_unit.sv | 37 +++
 rtl/addsub_arbiter.sv | 125 ++++++++++++
 tb/tb_addsub_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared widths, op encodings and FSM state codes for addsub_arbiter
//
// Purpose: common definitions imported by addsub_unit and addsub_arbiter.
//   DATA_W          operand/result width
//   OP_ADD/OP_SUB   operation select encodings
//   state_t, ST_*   FSM state type and state codes (IDLE -> EXEC -> DONE)

package addsub_pkg;

  localparam int DATA_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational add/subtract unit with carry/borrow flag
//
// Purpose: computes a+b or a-b modulo 2**DATA_W.
// Ports:
//   a, b    operands
//   op      OP_ADD or OP_SUB
//   result  low DATA_W bits of the operation
//   flag    carry-out on add, borrow (a < b) on subtract

module addsub_unit
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result,
  output logic              flag
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit on both paths: the MSB is the carry for add, and for an
  // unsigned subtract it wraps to 1 exactly when a < b.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    if (op == OP_SUB) begin
      result = diff[DATA_W-1:0];
      flag   = diff[DATA_W];
    end else begin
      result = sum[DATA_W-1:0];
      flag   = sum[DATA_W];
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester arbiter sharing one add/subtract unit
//
// Purpose: grants one of two requesters, latches its operation and operands,
// computes the result in EXEC and strobes it in DONE (gnt at t, res_valid at t+2).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention handling;
// otherwise requester 0 has fixed priority.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en                   global enable, 0 blocks new grants (in-flight op completes)
//   req0/req1            operation requests
//   op0/op1              0 = add, 1 = subtract
//   a0/b0, a1/b1         operands per requester
//   gnt0/gnt1            one-cycle grant pulse (issued in IDLE)
//   busy                 high in EXEC and DONE
//   res_valid            one-cycle result strobe (DONE)
//   res_id               requester owning the result
//   res_data, res_flag   result modulo 16, carry/borrow
//   led_out              4'b1111 while en=0, else res_data

module addsub_arbiter
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              res_valid,
  output logic              res_id,
  output logic [DATA_W-1:0] res_data,
  output logic              res_flag,
  output logic [DATA_W-1:0] led_out
);

  state_t            state;
  logic              lat_op;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic              lat_id;
  logic              grant;
  logic              pick1;
  logic [DATA_W-1:0] unit_result;
  logic              unit_flag;

`ifdef ARB_ROUND_ROBIN_EN
  // Requester granted most recently; resets to 1 so requester 0 wins first.
  logic last_id;

  assign pick1 = req1 & (~req0 | ~last_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (grant) begin
      last_id <= pick1;
    end
  end
`else
  assign pick1 = req1 & ~req0;
`endif

  // Grant is a Mealy output of IDLE so that the result strobe lands exactly
  // two cycles after it; rst masks it immediately.
  assign grant     = (state == ST_IDLE) & en & (req0 | req1) & ~rst;
  assign gnt0      = grant & ~pick1;
  assign gnt1      = grant & pick1;
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign led_out   = en ? res_data : {DATA_W{1'b1}};

  addsub_unit u_addsub_unit (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (unit_result),
    .flag   (unit_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_op   <= OP_ADD;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_id   <= 1'b0;
      res_id   <= 1'b0;
      res_data <= '0;
      res_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state  <= ST_EXEC;
            lat_op <= pick1 ? op1 : op0;
            lat_a  <= pick1 ? a1 : a0;
            lat_b  <= pick1 ? b1 : b0;
            lat_id <= pick1;
          end
        end
        ST_EXEC: begin
          res_data <= unit_result;
          res_flag <= unit_flag;
          res_id   <= lat_id;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - scoreboard bench for addsub_arbiter

module tb_addsub_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req0;
  logic       req1;
  logic       op0;
  logic       op1;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       res_valid;
  logic       res_id;
  logic [3:0] res_data;
  logic       res_flag;
  logic [3:0] led_out;

  addsub_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req0      (req0),
    .req1      (req1),
    .op0       (op0),
    .op1       (op1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_flag  (res_flag),
    .led_out   (led_out)
  );

  typedef struct {
    int id;
    int data;
    int flag;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  int   free_at = 0;
  int   last_gnt = 1;
  int   led_data = 0;
  int   pend_data = 0;
  int   pend_due = 0;
  bit   pend_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the arbiter's response and check it.
  task automatic step(input logic e, input logic r0, input logic r1,
                      input logic o0, input logic o1,
                      input logic [3:0] xa0, input logic [3:0] xb0,
                      input logic [3:0] xa1, input logic [3:0] xb1);
    bit idle;
    int win, ea, eb, eo, data, flag;
    @(negedge clk);
    en = e; req0 = r0; req1 = r1; op0 = o0; op1 = o1;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    #2;
    idle = (cyc >= free_at);
    if (pend_valid && cyc >= pend_due) begin
      led_data   = pend_data;
      pend_valid = 0;
    end
    win = -1;
    if (idle && e && (r0 || r1)) begin
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = (last_gnt == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else begin
        win = r1 ? 1 : 0;
      end
      ea = (win == 1) ? int'(xa1) : int'(xa0);
      eb = (win == 1) ? int'(xb1) : int'(xb0);
      eo = (win == 1) ? int'(o1) : int'(o0);
      if (eo == 0) begin
        data = (ea + eb) % 16;
        flag = (ea + eb > 15) ? 1 : 0;
      end else begin
        data = (ea - eb + 16) % 16;
        flag = (ea < eb) ? 1 : 0;
      end
      q.push_back('{win, data, flag, cyc + 2});
      free_at    = cyc + 3;
      last_gnt   = win;
      pend_data  = data;
      pend_due   = cyc + 2;
      pend_valid = 1;
    end
    chk("gnt0", int'(gnt0), (win == 0) ? 1 : 0);
    chk("gnt1", int'(gnt1), (win == 1) ? 1 : 0);
    chk("busy", int'(busy), idle ? 0 : 1);
    chk("led_out", int'(led_out), e ? led_data : 15);
  endtask

  task automatic idle_steps(input int n, input logic e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #2;
    q.delete();
    free_at = 0; last_gnt = 1; led_data = 0; pend_valid = 0;
    chk("rst_gnt0", int'(gnt0), 0);
    chk("rst_gnt1", int'(gnt1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_flag", int'(res_flag), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (res_valid) begin
          if (q.size() == 0) begin
            chk("res_valid_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("res_latency", cyc, e.due);
            chk("res_id", int'(res_id), e.id);
            chk("res_data", int'(res_data), e.data);
            chk("res_flag", int'(res_flag), e.flag);
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          chk("res_valid_missing", 0, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
    do_reset();

    // 9+8 on requester 0, then requester 1 subtracts
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd8, 4'd0, 4'd0);
    idle_steps(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 4'd5);
    idle_steps(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd2);
    idle_steps(3, 1'b1);

    // Both requesters held high: contention sequence
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    idle_steps(3, 1'b1);

    // en low blocks grants, then raising it grants requester 0
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 4'd0);
    // en drops mid-operation: result still completes
    idle_steps(3, 1'b0);

    // Reset in EXEC discards the operation
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 4'd15);
    idle_steps(3, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else
        step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    idle_steps(4, 1'b1);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
